mux_arb_nx1: RTL and testbench

Parametrised N-to-1 data selector with a registered valid/ready output, succeeding the fixed 3:1 combinational selector. It arbitrates among `N_IN` requesters using fixed-priority or round-robin arbitration, or honours an explicit select override. It sits between multiple producers and one consumer, such as shared memory or write-back ports in the pipelined core.

---
 rtl/mux_arb_nx1_pkg.sv | 7 +
 rtl/rr_grant_nx1.sv | 35 +++
 rtl/mux_arb_nx1.sv | 113 +++++++++++
 tb/tb_mux_arb_nx1.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nx1_pkg.sv
// Shared arbitration constants for the N-to-1 selector family.
package mux_arb_nx1_pkg;

    localparam int unsigned MUX_MODE_FIXED = 0;
    localparam int unsigned MUX_MODE_RR    = 1;

endpackage

// File: rtl/rr_grant_nx1.sv
// Combinational one-hot grant: fixed priority from channel 0, or round-robin
// starting just after rr_ptr and wrapping modulo N_IN.
module rr_grant_nx1 #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] rr_ptr,
    input  logic             rr_mode,
    output logic [N_IN-1:0]  grant_c
);

    int unsigned base;
    int unsigned idx;
    logic        found;

    // rr_ptr <= N_IN-1, so base + i stays below 2*N_IN and one subtract wraps it
    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        base    = rr_mode ? (32'(rr_ptr) + 32'd1) : 32'd0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            idx = base + i;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!found && req[SEL_W'(idx)]) begin
                grant_c[SEL_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-to-1 arbitrated data selector with a registered valid/ready output stage
// and an explicit channel-select override.
module mux_arb_nx1
    import mux_arb_nx1_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned MODE  = MUX_MODE_RR,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  sel_force_en,
    input  logic [SEL_W-1:0]      sel_force,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic RR_EN = (MODE == MUX_MODE_RR);

    logic [N_IN-1:0]  grant_c;
    logic [SEL_W-1:0] g_c;
    logic             g_valid_c;
    logic [WIDTH-1:0] g_data_c;
    logic             space_c;
    logic             xfer_c;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    rr_grant_nx1 #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_grant (
        .req     (in_valid),
        .rr_ptr  (rr_ptr_q),
        .rr_mode (RR_EN),
        .grant_c (grant_c)
    );

    // Grant selection, handshake and next-state for the output register
    always_comb begin
        g_c         = '0;
        g_valid_c   = 1'b0;
        g_data_c    = '0;
        in_ready    = '0;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        space_c     = !out_valid_q || out_ready;

        if (sel_force_en) begin
            // Out-of-range force index falls back to channel 0
            g_c = (32'(sel_force) >= N_IN) ? '0 : sel_force;
        end else begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                if (grant_c[k]) begin
                    g_c = SEL_W'(k);
                end
            end
        end

        for (int unsigned k = 0; k < N_IN; k++) begin
            if (g_c == SEL_W'(k)) begin
                g_valid_c = in_valid[k];
                g_data_c  = in_data[k*WIDTH +: WIDTH];
            end
        end

        xfer_c = space_c && g_valid_c;
        for (int unsigned k = 0; k < N_IN; k++) begin
            in_ready[k] = xfer_c && (g_c == SEL_W'(k));
        end

        if (xfer_c) begin
            out_data_d  = g_data_c;
            out_sel_d   = g_c;
            out_valid_d = 1'b1;
            if (RR_EN) begin
                rr_ptr_d = g_c;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: three instances (4ch RR, 4ch fixed, 3ch RR) share one
// stimulus and are checked every cycle against a queue-free behavioural model.
module tb_mux_arb_nx1;
    import mux_arb_nx1_pkg::*;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_valid;
    logic           sel_force_en;
    logic [1:0]     sel_force;
    logic           out_ready;

    logic [3:0]   rdy_rr, rdy_fp;
    logic [2:0]   rdy_n3;
    logic [W-1:0] od_rr, od_fp, od_n3;
    logic [1:0]   os_rr, os_fp, os_n3;
    logic         ov_rr, ov_fp, ov_n3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arb_nx1 #(.WIDTH(W), .N_IN(4), .MODE(MUX_MODE_RR)) u_rr (
        .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_rr), .sel_force_en(sel_force_en), .sel_force(sel_force),
        .out_data(od_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(out_ready)
    );

    mux_arb_nx1 #(.WIDTH(W), .N_IN(4), .MODE(MUX_MODE_FIXED)) u_fp (
        .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_fp), .sel_force_en(sel_force_en), .sel_force(sel_force),
        .out_data(od_fp), .out_sel(os_fp), .out_valid(ov_fp), .out_ready(out_ready)
    );

    mux_arb_nx1 #(.WIDTH(W), .N_IN(3), .MODE(MUX_MODE_RR)) u_n3 (
        .clk(clk), .rst(rst_n), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]),
        .in_ready(rdy_n3), .sel_force_en(sel_force_en), .sel_force(sel_force),
        .out_data(od_n3), .out_sel(os_n3), .out_valid(ov_n3), .out_ready(out_ready)
    );

    // Behavioural model state, one slot per instance
    logic [W-1:0] m_data  [3];
    int           m_sel   [3];
    logic         m_valid [3];
    int           m_ptr   [3];

    function automatic int n_of(int j);
        return (j == 2) ? 3 : 4;
    endfunction

    function automatic bit rr_of(int j);
        return (j != 1);
    endfunction

    // Channel that would be granted this cycle, or -1 when that channel is idle
    function automatic int grant(int j);
        int n;
        int g;
        n = n_of(j);
        if (sel_force_en) begin
            g = (int'(sel_force) >= n) ? 0 : int'(sel_force);
            return in_valid[g] ? g : -1;
        end
        for (int i = 0; i < n; i++) begin
            g = rr_of(j) ? ((m_ptr[j] + 1 + i) % n) : i;
            if (in_valid[g]) return g;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int j);
        logic [3:0] r;
        int g;
        r = 4'b0;
        g = grant(j);
        if (g >= 0 && (!m_valid[j] || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                m_data[j]  <= '0;
                m_sel[j]   <= 0;
                m_valid[j] <= 1'b0;
                m_ptr[j]   <= n_of(j) - 1;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (grant(j) >= 0 && (!m_valid[j] || out_ready)) begin
                    m_data[j]  <= in_data[grant(j)*W +: W];
                    m_sel[j]   <= grant(j);
                    m_valid[j] <= 1'b1;
                    if (rr_of(j)) m_ptr[j] <= grant(j);
                end else if (out_ready) begin
                    m_valid[j] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [W-1:0] a_data [3];
    logic [1:0]   a_sel  [3];
    logic         a_vld  [3];
    logic [3:0]   a_rdy  [3];
    assign a_data[0] = od_rr;  assign a_data[1] = od_fp;  assign a_data[2] = od_n3;
    assign a_sel[0]  = os_rr;  assign a_sel[1]  = os_fp;  assign a_sel[2]  = os_n3;
    assign a_vld[0]  = ov_rr;  assign a_vld[1]  = ov_fp;  assign a_vld[2]  = ov_n3;
    assign a_rdy[0]  = rdy_rr; assign a_rdy[1]  = rdy_fp; assign a_rdy[2]  = {1'b0, rdy_n3};

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("model_valid[%0d]", j), 32'(a_vld[j]), 32'(m_valid[j]));
            chk($sformatf("model_data[%0d]", j), a_data[j], m_data[j]);
            chk($sformatf("model_sel[%0d]", j), 32'(a_sel[j]), 32'(m_sel[j]));
            chk($sformatf("model_rdy[%0d]", j), 32'(a_rdy[j]), 32'(exp_rdy(j)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = '0;
        sel_force_en = 1'b0;
        sel_force    = '0;
        out_ready    = 1'b0;

        step(2);
        chk("rst_valid", 32'(ov_rr), 32'd0);
        chk("rst_data", od_rr, 32'd0);
        chk("rst_sel", 32'(os_rr), 32'd0);

        rst_n = 1'b1;
        step(2);
        chk("idle_rdy", 32'(rdy_rr), 32'd0);
        chk("idle_valid", 32'(ov_rr), 32'd0);

        for (int k = 0; k < 4; k++) in_data[k*W +: W] = 32'hA0 + 32'(k);
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("rr_sel", 32'(os_rr), 32'(k % 4));
            chk("rr_data", od_rr, 32'hA0 + 32'(k % 4));
            chk("rr_valid", 32'(ov_rr), 32'd1);
            chk("rr3_sel", 32'(os_n3), 32'(k % 3));
            chk("fp_always0", 32'(os_fp), 32'd0);
        end

        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("fp_sel1", 32'(os_fp), 32'd1);
            chk("fp_rdy1", 32'(rdy_fp), 32'b0010);
        end
        in_valid = 4'b1000;
        #1;
        chk("fp_rdy3", 32'(rdy_fp), 32'b1000);
        step(1);
        chk("fp_sel3", 32'(os_fp), 32'd3);

        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("bp_rdy", 32'(rdy_fp), 32'd0);
            chk("bp_data", od_fp, 32'hA3);
            chk("bp_valid", 32'(ov_fp), 32'd1);
        end
        out_ready = 1'b1;
        step(1);
        chk("bp_fill_valid", 32'(ov_fp), 32'd1);
        chk("bp_fill_sel", 32'(os_fp), 32'd0);
        chk("bp_fill_data", od_fp, 32'hA0);

        in_valid           = 4'b0100;
        in_data[2*W +: W]  = 32'h1234;
        sel_force_en       = 1'b1;
        sel_force          = 2'd2;
        step(1);
        chk("force_data", od_rr, 32'h1234);
        chk("force_sel", 32'(os_rr), 32'd2);
        chk("force_sel_fp", 32'(os_fp), 32'd2);

        in_data[W-1:0] = 32'h55;
        in_valid       = 4'b0001;
        sel_force      = 2'd3;
        #1;
        chk("force_oob_rdy", 32'(rdy_n3), 32'b001);
        chk("force_miss_rdy", 32'(rdy_rr), 32'd0);
        step(1);
        chk("force_oob_sel", 32'(os_n3), 32'd0);
        chk("force_oob_data", od_n3, 32'h55);
        chk("force_miss_valid", 32'(ov_rr), 32'd0);

        sel_force_en = 1'b0;
        sel_force    = 2'd0;
        in_valid     = 4'hF;
        out_ready    = 1'b0;
        step(1);
        chk("pre_rst_valid", 32'(ov_rr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov_rr), 32'd0);
        chk("mid_rst_data", od_rr, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step(1);
        chk("post_rst_sel", 32'(os_rr), 32'd0);
        chk("post_rst_valid", 32'(ov_rr), 32'd1);
        step(1);
        chk("post_rst_sel2", 32'(os_rr), 32'd1);
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
